llsc_link_ctrl: RTL and testbench
=================================

Name: llsc_link_ctrl

Overview:
- Controller for the LL/SC atomic link bit; it sequences LL/SC pairs for the MEM stage.
- Tracks linked address and link state, clears the link on exception, ERET or conflicting snoop write.
- Arbitrates the SC store onto the data-memory port with a req/ack handshake, and stalls the pipeline until the SC outcome is known.
- Produces the SC result written back into rt (1 = success, 0 = fail).

Parameters:
ADDR_W, 32, address width
GRAN_LSB, 2, low address bits ignored in link compare (granule = 2^GRAN_LSB bytes)
ACK_TIMEOUT, 16, max cycles waiting for mem_ack_i before SC is forced to fail

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low (0 = reset)
ll_i  input  1  LL in MEM stage this cycle (single-cycle pulse)
sc_i  input  1  SC in MEM stage this cycle (single-cycle pulse)
addr_i  input  ADDR_W  effective address of LL/SC
exc_flg_i  input  1  exception taken this cycle
eret_i  input  1  ERET committed this cycle
snoop_we_i  input  1  store by another master/DMA
snoop_addr_i  input  ADDR_W  address of snooped store
mem_req_o  output  1  SC store request to data-memory port
mem_ack_i  input  1  memory accepted SC store
stall_o  output  1  hold pipeline while SC in flight
sc_valid_o  output  1  one-cycle pulse: sc_result_o valid
sc_result_o  output  1  1 = SC succeeded, 0 = failed
atomicbit_o  output  1  current link bit (CP0-visible)
link_addr_o  output  ADDR_W  current linked address

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; atomicbit_o=0; link_addr_o=0; mem_req_o=0; stall_o=0; sc_valid_o=0; sc_result_o=0; timeout counter=0. Reset mid-SC aborts the request with no result pulse.
- match(a) := a[ADDR_W-1:GRAN_LSB] == link_addr_o[ADDR_W-1:GRAN_LSB].
- Kill condition each cycle: exc_flg_i | eret_i | (snoop_we_i & match(snoop_addr_i)).
- States:
  - IDLE: link bit = 0.
  - LINKED: link bit = 1.
  - SC_REQ: request outstanding.
  - SC_RESP: result cycle.
- IDLE:
  - ll_i & !exc_flg_i: link_addr <= addr_i; go to LINKED.
  - sc_i: no memory request; go to SC_RESP with result 0.
- LINKED:
  - Kill: go to IDLE, atomicbit <= 0.
  - ll_i (no kill): re-link to the new addr_i; stay in LINKED.
  - sc_i & match(addr_i) & no kill: go to SC_REQ; mem_req_o=1 and stall_o=1 registered in the next cycle.
  - sc_i with address mismatch or kill: go to SC_RESP, result 0, atomicbit <= 0.
- SC_REQ:
  - mem_req_o=1 and stall_o=1 are held until mem_ack_i; the counter increments each cycle.
  - mem_ack_i & no kill in the same cycle: result 1.
  - Kill before or coinciding with ack: drop mem_req_o next cycle, result 0. Memory must treat a dropped request as not issued; an ack in a kill cycle is ignored.
  - Counter reaches ACK_TIMEOUT-1 without ack: result 0.
  - All exits go to SC_RESP and clear atomicbit.
- SC_RESP: sc_valid_o=1 for exactly one cycle with sc_result_o; stall_o=0; mem_req_o=0; go to IDLE. Link is always consumed by SC (MIPS semantics).
- Latency:
  - Failing SC: result pulse 1 cycle after sc_i, no stall.
  - Successful SC: stall from cycle sc_i+1 until the ack cycle; result the cycle after the ack.
- Priority within one cycle: reset > exc_flg_i > eret_i > snoop kill > sc_i > ll_i.
- ll_i and sc_i asserted together is illegal; treat as sc_i and flag with an assertion.
- atomicbit_o, link_addr_o, mem_req_o and stall_o are registered outputs.
- sc_valid_o and sc_result_o are registered.
- Snoop with snoop_we_i=0 has no effect. Snoop match ignores the GRAN_LSB low bits.

Decomposition:
- Shared defines header: state encodings (LLSC_IDLE=2'd0, LLSC_LINKED=2'd1, LLSC_SC_REQ=2'd2, LLSC_SC_RESP=2'd3), the SC result constants, and the reset-active level constant (RST_ACTIVE=1'b0).
- Natural sub-module: llsc_timeout_cnt, a loadable/clearable wait counter with an expiry flag.
- Link-compare logic stays inline.

Test Plan:
- LL @0x1000 then SC @0x1000, mem_ack_i 3 cycles after req -> stall_o high 3 cycles; sc_valid_o with sc_result_o=1; atomicbit_o returns to 0.
- LL @0x1000, snoop_we_i @0x1002 (GRAN_LSB=2), then SC @0x1000 -> no mem_req_o; sc_result_o=0 one cycle after sc_i.
- LL @0x1000, exc_flg_i pulse, then SC -> atomicbit_o=0 the cycle after the exception; sc_result_o=0.
- LL @0x2000, SC @0x2000, mem_ack_i never asserted -> mem_req_o held 16 cycles, then sc_result_o=0 and stall_o drops.
- LL, SC in flight, eret_i and mem_ack_i in the same cycle -> sc_result_o=0; mem_req_o low next cycle.
- rst=0 during SC_REQ -> next cycle all outputs 0 and state IDLE; no sc_valid_o pulse.

Source files
------------

// File: rtl/llsc_link_ctrl_pkg.sv
// llsc_link_ctrl_pkg
// Shared constants for the LL/SC link controller slice:
//   - FSM state encodings (2-bit, legacy-compatible localparams)
//   - SC result values written back into rt
//   - reset-active level for the synchronous active-low reset
package llsc_link_ctrl_pkg;

    localparam int LLSC_STATE_W = 2;

    localparam logic [LLSC_STATE_W-1:0] LLSC_IDLE    = 2'd0;
    localparam logic [LLSC_STATE_W-1:0] LLSC_LINKED  = 2'd1;
    localparam logic [LLSC_STATE_W-1:0] LLSC_SC_REQ  = 2'd2;
    localparam logic [LLSC_STATE_W-1:0] LLSC_SC_RESP = 2'd3;

    localparam logic SC_RESULT_FAIL = 1'b0;
    localparam logic SC_RESULT_OK   = 1'b1;

    localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/llsc_timeout_cnt.sv
// llsc_timeout_cnt
// Wait counter for an outstanding SC store. Cleared while clr is high,
// counts up one per cycle while en is high, and saturates at LIMIT-1.
// expired is high in the cycle the count sits at LIMIT-1 while enabled,
// i.e. in the LIMIT-th enabled cycle after a clear.
// Ports:
//   clk     clock
//   rst     synchronous reset, active-low
//   clr     synchronous clear (returns count to 0)
//   en      count enable
//   expired count has reached LIMIT-1 while enabled
module llsc_timeout_cnt
    import llsc_link_ctrl_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE || clr) begin
            cnt <= '0;
        end else if (en && cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/llsc_link_ctrl.sv
// llsc_link_ctrl
// LL/SC link-bit controller for the MEM stage. Remembers the linked
// address after LL, drops the link on exception, ERET or a matching
// snoop store, and turns an SC into either an immediate failure or a
// req/ack store on the data-memory port, stalling the pipeline until
// the outcome is known. The SC outcome is pulsed for one cycle.
//
// Handshake: mem_req_o is raised the cycle after an accepted SC and held
// until the cycle in which mem_ack_i is sampled high; that cycle completes
// the store. If the request is killed (or times out) mem_req_o drops the
// next cycle and the memory must treat the request as never issued; an ack
// coinciding with a kill is ignored.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   ll_i, sc_i          LL / SC in MEM this cycle (one-cycle pulses)
//   addr_i              effective address of the LL/SC
//   exc_flg_i, eret_i   exception taken / ERET committed
//   snoop_we_i/addr_i   store from another master
//   mem_req_o/mem_ack_i SC store handshake to data memory
//   stall_o             pipeline hold while the SC store is in flight
//   sc_valid_o          one-cycle pulse, sc_result_o valid
//   sc_result_o         1 = SC succeeded, 0 = failed
//   atomicbit_o         current link bit
//   link_addr_o         current linked address
//   state_o             FSM state (debug)
module llsc_link_ctrl
    import llsc_link_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int GRAN_LSB    = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ll_i,
    input  logic              sc_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              exc_flg_i,
    input  logic              eret_i,
    input  logic              snoop_we_i,
    input  logic [ADDR_W-1:0] snoop_addr_i,
    output logic              mem_req_o,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              sc_valid_o,
    output logic              sc_result_o,
    output logic              atomicbit_o,
    output logic [ADDR_W-1:0] link_addr_o,
    output logic [1:0]        state_o
);

    logic [LLSC_STATE_W-1:0] state_q;
    logic sc_match;
    logic snoop_hit;
    logic kill;
    logic tmo_expired;
    logic in_req;

    // Addresses match when they fall in the same granule; the XOR/shift
    // form discards the low GRAN_LSB bits.
    assign sc_match  = (((addr_i ^ link_addr_o) >> GRAN_LSB) == '0);
    assign snoop_hit = snoop_we_i && (((snoop_addr_i ^ link_addr_o) >> GRAN_LSB) == '0);
    assign kill      = exc_flg_i || eret_i || snoop_hit;
    assign in_req    = (state_q == LLSC_SC_REQ);

    llsc_timeout_cnt #(
        .LIMIT (ACK_TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_req),
        .en      (in_req),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            state_q     <= LLSC_IDLE;
            atomicbit_o <= 1'b0;
            link_addr_o <= '0;
            mem_req_o   <= 1'b0;
            stall_o     <= 1'b0;
            sc_valid_o  <= 1'b0;
            sc_result_o <= SC_RESULT_FAIL;
        end else begin
            // Result outputs are a one-cycle pulse unless set below.
            sc_valid_o  <= 1'b0;
            sc_result_o <= SC_RESULT_FAIL;
            case (state_q)
                LLSC_IDLE: begin
                    if (sc_i) begin
                        // No link held: fail without touching memory.
                        state_q    <= LLSC_SC_RESP;
                        sc_valid_o <= 1'b1;
                    end else if (ll_i && !exc_flg_i && !eret_i) begin
                        link_addr_o <= addr_i;
                        atomicbit_o <= 1'b1;
                        state_q     <= LLSC_LINKED;
                    end
                end
                LLSC_LINKED: begin
                    if (sc_i) begin
                        if (sc_match && !kill) begin
                            state_q   <= LLSC_SC_REQ;
                            mem_req_o <= 1'b1;
                            stall_o   <= 1'b1;
                        end else begin
                            state_q     <= LLSC_SC_RESP;
                            sc_valid_o  <= 1'b1;
                            atomicbit_o <= 1'b0;
                        end
                    end else if (kill) begin
                        state_q     <= LLSC_IDLE;
                        atomicbit_o <= 1'b0;
                    end else if (ll_i) begin
                        link_addr_o <= addr_i;
                    end
                end
                LLSC_SC_REQ: begin
                    if (kill || mem_ack_i || tmo_expired) begin
                        state_q     <= LLSC_SC_RESP;
                        mem_req_o   <= 1'b0;
                        stall_o     <= 1'b0;
                        atomicbit_o <= 1'b0;
                        sc_valid_o  <= 1'b1;
                        // A kill overrides an ack in the same cycle.
                        sc_result_o <= (mem_ack_i && !kill) ? SC_RESULT_OK : SC_RESULT_FAIL;
                    end
                end
                default: begin
                    // LLSC_SC_RESP: the result pulse is on the outputs now.
                    state_q <= LLSC_IDLE;
                end
            endcase
        end
    end

    assign state_o = state_q;

    ll_sc_exclusive: assert property (@(posedge clk) disable iff (rst == RST_ACTIVE) !(ll_i && sc_i));

endmodule

// File: tb/tb_llsc_link_ctrl.sv
// tb_llsc_link_ctrl
// Directed scenarios for the LL/SC controller plus a randomized run
// checked against a transaction-level model of the link and SC outcome.
module tb_llsc_link_ctrl;
    import llsc_link_ctrl_pkg::*;

    localparam int ADDR_W      = 32;
    localparam int GRAN_LSB    = 2;
    localparam int ACK_TIMEOUT = 16;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              ll_i = 1'b0;
    logic              sc_i = 1'b0;
    logic [ADDR_W-1:0] addr_i = '0;
    logic              exc_flg_i = 1'b0;
    logic              eret_i = 1'b0;
    logic              snoop_we_i = 1'b0;
    logic [ADDR_W-1:0] snoop_addr_i = '0;
    logic              mem_ack_i = 1'b0;
    logic              mem_req_o;
    logic              stall_o;
    logic              sc_valid_o;
    logic              sc_result_o;
    logic              atomicbit_o;
    logic [ADDR_W-1:0] link_addr_o;
    logic [1:0]        state_o;

    llsc_link_ctrl #(
        .ADDR_W      (ADDR_W),
        .GRAN_LSB    (GRAN_LSB),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ll_i         (ll_i),
        .sc_i         (sc_i),
        .addr_i       (addr_i),
        .exc_flg_i    (exc_flg_i),
        .eret_i       (eret_i),
        .snoop_we_i   (snoop_we_i),
        .snoop_addr_i (snoop_addr_i),
        .mem_req_o    (mem_req_o),
        .mem_ack_i    (mem_ack_i),
        .stall_o      (stall_o),
        .sc_valid_o   (sc_valid_o),
        .sc_result_o  (sc_result_o),
        .atomicbit_o  (atomicbit_o),
        .link_addr_o  (link_addr_o),
        .state_o      (state_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: link held?, linked address, SC store outstanding,
    // cycles the store has waited, result due on the outputs now.
    logic              m_link = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic              m_busy = 1'b0;
    int                m_wait = 0;
    logic              m_res_pend = 1'b0;
    logic              m_res = 1'b0;
    logic [0:0]        exp_q[$];

    function automatic logic same_granule(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return (a >> GRAN_LSB) == (b >> GRAN_LSB);
    endfunction

    task automatic model_finish(input logic r);
        m_busy     = 1'b0;
        m_link     = 1'b0;
        m_res_pend = 1'b1;
        m_res      = r;
        exp_q.push_back(r);
    endtask

    // Advance the model by one clock using the inputs as they are now.
    task automatic model_step();
        logic k;
        k = exc_flg_i || eret_i || (snoop_we_i && same_granule(snoop_addr_i, m_addr));
        if (rst == 1'b0) begin
            m_link = 1'b0; m_addr = '0; m_busy = 1'b0; m_wait = 0;
            m_res_pend = 1'b0; m_res = 1'b0;
            exp_q.delete();
        end else if (m_res_pend) begin
            m_res_pend = 1'b0;
        end else if (m_busy) begin
            m_wait++;
            if (k) model_finish(1'b0);
            else if (mem_ack_i) model_finish(1'b1);
            else if (m_wait == ACK_TIMEOUT) model_finish(1'b0);
        end else if (sc_i) begin
            if (m_link && same_granule(addr_i, m_addr) && !k) begin
                m_busy = 1'b1;
                m_wait = 0;
            end else begin
                model_finish(1'b0);
            end
        end else if (m_link && k) begin
            m_link = 1'b0;
        end else if (ll_i && !exc_flg_i && !eret_i) begin
            m_link = 1'b1;
            m_addr = addr_i;
        end
    endtask

    // driver tasks
    task automatic clear_inputs();
        ll_i = 1'b0; sc_i = 1'b0; exc_flg_i = 1'b0; eret_i = 1'b0;
        snoop_we_i = 1'b0; mem_ack_i = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ll(input logic [ADDR_W-1:0] a);
        ll_i = 1'b1; addr_i = a;
        tick();
        ll_i = 1'b0;
    endtask

    task automatic do_sc(input logic [ADDR_W-1:0] a);
        sc_i = 1'b1; addr_i = a;
        tick();
        sc_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        tick(); tick();
        n_cmp++; if ({mem_req_o, stall_o, sc_valid_o, sc_result_o, atomicbit_o} !== 5'b0) begin
            n_err++; $display("FAIL reset_outs got=%b exp=00000", {mem_req_o, stall_o, sc_valid_o, sc_result_o, atomicbit_o});
        end
        n_cmp++; if (link_addr_o !== '0) begin
            n_err++; $display("FAIL reset_link_addr got=%h exp=0", link_addr_o);
        end
        n_cmp++; if (state_o !== LLSC_IDLE) begin
            n_err++; $display("FAIL reset_state got=%0d exp=%0d", state_o, LLSC_IDLE);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_sc_success();
        int stall_cycles = 0;
        do_ll(32'h1000);
        n_cmp++; if (atomicbit_o !== 1'b1 || link_addr_o !== 32'h1000) begin
            n_err++; $display("FAIL ll_link got=%b/%h exp=1/00001000", atomicbit_o, link_addr_o);
        end
        do_sc(32'h1000);
        for (int i = 0; i < 3; i++) begin
            if (stall_o && mem_req_o) stall_cycles++;
            if (i == 2) mem_ack_i = 1'b1;
            tick();
            mem_ack_i = 1'b0;
        end
        n_cmp++; if (stall_cycles != 3) begin
            n_err++; $display("FAIL sc_ok_stall_cycles got=%0d exp=3", stall_cycles);
        end
        n_cmp++; if (sc_valid_o !== 1'b1 || sc_result_o !== 1'b1) begin
            n_err++; $display("FAIL sc_ok_result got=%b/%b exp=1/1", sc_valid_o, sc_result_o);
        end
        n_cmp++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || atomicbit_o !== 1'b0) begin
            n_err++; $display("FAIL sc_ok_after got=%b%b%b exp=000", stall_o, mem_req_o, atomicbit_o);
        end
        tick();
        n_cmp++; if (sc_valid_o !== 1'b0) begin
            n_err++; $display("FAIL sc_ok_one_pulse got=%b exp=0", sc_valid_o);
        end
    endtask

    task automatic test_snoop_kill();
        do_ll(32'h1000);
        // Different granule, and a non-write snoop to the same word: no effect.
        snoop_we_i = 1'b1; snoop_addr_i = 32'h1004;
        tick();
        snoop_we_i = 1'b0; snoop_addr_i = 32'h1000;
        tick();
        n_cmp++; if (atomicbit_o !== 1'b1) begin
            n_err++; $display("FAIL snoop_miss_keeps_link got=%b exp=1", atomicbit_o);
        end
        snoop_we_i = 1'b1; snoop_addr_i = 32'h1002;
        tick();
        snoop_we_i = 1'b0;
        n_cmp++; if (atomicbit_o !== 1'b0) begin
            n_err++; $display("FAIL snoop_hit_clears got=%b exp=0", atomicbit_o);
        end
        do_sc(32'h1000);
        n_cmp++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || sc_valid_o !== 1'b1 || sc_result_o !== 1'b0) begin
            n_err++; $display("FAIL snoop_sc_fail got=%b%b%b%b exp=0010", mem_req_o, stall_o, sc_valid_o, sc_result_o);
        end
        tick();
    endtask

    task automatic test_exception();
        do_ll(32'h1000);
        exc_flg_i = 1'b1;
        tick();
        exc_flg_i = 1'b0;
        n_cmp++; if (atomicbit_o !== 1'b0) begin
            n_err++; $display("FAIL exc_clears_link got=%b exp=0", atomicbit_o);
        end
        do_sc(32'h1000);
        n_cmp++; if (mem_req_o !== 1'b0 || sc_valid_o !== 1'b1 || sc_result_o !== 1'b0) begin
            n_err++; $display("FAIL exc_sc_fail got=%b%b%b exp=010", mem_req_o, sc_valid_o, sc_result_o);
        end
        tick();
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        do_ll(32'h2000);
        do_sc(32'h2000);
        while (mem_req_o && req_cycles < 40) begin
            req_cycles++;
            tick();
        end
        n_cmp++; if (req_cycles != ACK_TIMEOUT) begin
            n_err++; $display("FAIL timeout_req_cycles got=%0d exp=%0d", req_cycles, ACK_TIMEOUT);
        end
        n_cmp++; if (sc_valid_o !== 1'b1 || sc_result_o !== 1'b0 || stall_o !== 1'b0) begin
            n_err++; $display("FAIL timeout_result got=%b%b%b exp=100", sc_valid_o, sc_result_o, stall_o);
        end
        tick();
    endtask

    task automatic test_eret_ack();
        do_ll(32'h3000);
        do_sc(32'h3000);
        tick();
        eret_i = 1'b1; mem_ack_i = 1'b1;
        tick();
        eret_i = 1'b0; mem_ack_i = 1'b0;
        n_cmp++; if (mem_req_o !== 1'b0 || sc_valid_o !== 1'b1 || sc_result_o !== 1'b0) begin
            n_err++; $display("FAIL eret_ack got=%b%b%b exp=010", mem_req_o, sc_valid_o, sc_result_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_sc();
        do_ll(32'h5000);
        do_sc(32'h5000);
        rst = 1'b0;
        tick();
        n_cmp++; if ({mem_req_o, stall_o, sc_valid_o, sc_result_o, atomicbit_o} !== 5'b0 || link_addr_o !== '0) begin
            n_err++; $display("FAIL rst_mid_sc got=%b/%h exp=00000/0", {mem_req_o, stall_o, sc_valid_o, sc_result_o, atomicbit_o}, link_addr_o);
        end
        n_cmp++; if (state_o !== LLSC_IDLE) begin
            n_err++; $display("FAIL rst_mid_sc_state got=%0d exp=%0d", state_o, LLSC_IDLE);
        end
        rst = 1'b1;
        tick();
        n_cmp++; if (sc_valid_o !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_sc_no_pulse got=%b exp=0", sc_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        // Relink, then SC in the same granule with an immediate ack.
        do_ll(32'h6000);
        do_ll(32'h7000);
        n_cmp++; if (link_addr_o !== 32'h7000) begin
            n_err++; $display("FAIL relink_addr got=%h exp=00007000", link_addr_o);
        end
        do_sc(32'h7003);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        n_cmp++; if (sc_valid_o !== 1'b1 || sc_result_o !== 1'b1) begin
            n_err++; $display("FAIL granule_sc_ok got=%b/%b exp=1/1", sc_valid_o, sc_result_o);
        end
        tick();
        // Link consumed: the next SC fails at once.
        do_sc(32'h7000);
        n_cmp++; if (sc_valid_o !== 1'b1 || sc_result_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_err++; $display("FAIL sc_after_consume got=%b%b%b exp=100", sc_valid_o, sc_result_o, mem_req_o);
        end
        tick();
    endtask

    task automatic test_random(input int n);
        logic [0:0] exp_r;
        rst = 1'b0;
        clear_inputs();
        tick();
        rst = 1'b1;
        for (int c = 0; c < n; c++) begin
            clear_inputs();
            rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            if (!m_busy && !m_res_pend) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: ll_i = 1'b1;
                    3, 4:    sc_i = 1'b1;
                    default: ;
                endcase
                addr_i = 32'h4000 + ADDR_W'($urandom_range(0, 15));
            end
            exc_flg_i    = ($urandom_range(0, 39) == 0);
            eret_i       = ($urandom_range(0, 39) == 0);
            snoop_we_i   = ($urandom_range(0, 11) == 0);
            snoop_addr_i = 32'h4000 + ADDR_W'($urandom_range(0, 15));
            mem_ack_i    = m_busy && ($urandom_range(0, 3) == 0);
            tick();
            n_cmp++; if (atomicbit_o !== m_link) begin
                n_err++; $display("FAIL rnd_atomicbit cyc=%0d got=%b exp=%b", c, atomicbit_o, m_link);
            end
            n_cmp++; if (link_addr_o !== m_addr) begin
                n_err++; $display("FAIL rnd_link_addr cyc=%0d got=%h exp=%h", c, link_addr_o, m_addr);
            end
            n_cmp++; if (mem_req_o !== m_busy || stall_o !== m_busy) begin
                n_err++; $display("FAIL rnd_req_stall cyc=%0d got=%b%b exp=%b%b", c, mem_req_o, stall_o, m_busy, m_busy);
            end
            n_cmp++; if (sc_valid_o !== m_res_pend) begin
                n_err++; $display("FAIL rnd_sc_valid cyc=%0d got=%b exp=%b", c, sc_valid_o, m_res_pend);
            end
            if (sc_valid_o === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rnd_unexpected_result cyc=%0d got=%b exp=none", c, sc_result_o);
                end else begin
                    exp_r = exp_q.pop_front();
                    if (sc_result_o !== exp_r[0]) begin
                        n_err++; $display("FAIL rnd_sc_result cyc=%0d got=%b exp=%b", c, sc_result_o, exp_r[0]);
                    end
                end
            end
        end
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (exp_q.size() != 0) begin
            n_err++; $display("FAIL rnd_missing_results got=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_sc_success();
        test_snoop_kill();
        test_exception();
        test_timeout();
        test_eret_ack();
        test_reset_mid_sc();
        test_back_to_back();
        test_random(3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
